// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite animator.
// Imported by the controller and the pixel pipeline.
package sprite_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        PAUSE = 2'd1,
        DONE  = 2'd2
    } anim_state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 10;

endpackage

// File: rtl/sprite_animator_if.sv
// Sprite ROM read port: registered address out, palette index back.
// Data is expected to follow the address within the same cycle.
interface sprite_animator_if #(
    parameter int ADDR_W = 14,
    parameter int IDX_W  = 4
);
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q;

    modport master (output rom_addr, input rom_q);
    modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: play/pause/done FSM with tick and frame counters.
// Frames advance only on frame_start; restart wins over everything.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 6,
    parameter int FN_W        = $clog2(FRAMES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_start,
    input  logic            loop_mode,
    input  logic            anim_en,
    input  logic            anim_restart,
    output logic [FN_W-1:0] frame_num,
    output logic            anim_done
);

    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);
    localparam logic [FN_W-1:0]   FRAME_LAST = FN_W'(FRAMES - 1);

    anim_state_t       state, state_n;
    logic [TICK_W-1:0] tick, tick_n;
    logic [FN_W-1:0]   frame, frame_n;
    logic              done, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PLAY;
            tick  <= '0;
            frame <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            tick  <= tick_n;
            frame <= frame_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick;
        frame_n = frame;
        done_n  = done;
        if (anim_restart) begin
            tick_n  = '0;
            frame_n = '0;
            done_n  = 1'b0;
            state_n = anim_en ? PLAY : PAUSE;
        end else begin
            unique case (state)
                PLAY: begin
                    if (!anim_en) begin
                        state_n = PAUSE;
                    end else if (frame_start) begin
                        if (tick == TICK_LAST) begin
                            tick_n = '0;
                            if (frame != FRAME_LAST) begin
                                frame_n = frame + 1'b1;
                            end else if (loop_mode) begin
                                frame_n = '0;
                            end else begin
                                state_n = DONE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            tick_n = tick + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (anim_en) state_n = PLAY;
                end
                DONE: begin
                    state_n = DONE;
                end
                default: state_n = PLAY;
            endcase
        end
    end

    assign frame_num = frame;
    assign anim_done = done;

endmodule

// File: rtl/sprite_animator.sv
// Positioned, scaled, flippable animated sprite for the VGA path.
// Two-stage pipeline: address/hit register, then opacity and index.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int FRAMES      = 4,
    parameter int IDX_W       = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int FRAME_TICKS = 6,
    parameter int TRANSP_IDX  = 0
) (
    input  logic                       vga_clk,
    input  logic                       reset_n,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic                       blank,
    input  logic                       frame_start,
    input  logic [COORD_W-1:0]         pos_x,
    input  logic [COORD_W-1:0]         pos_y,
    input  logic                       flip_h,
    input  logic                       loop_mode,
    input  logic                       anim_en,
    input  logic                       anim_restart,
    sprite_animator_if.master          rom,
    output logic                       pixel_on,
    output logic [IDX_W-1:0]           pixel_idx,
    output logic [$clog2(FRAMES)-1:0]  frame_num,
    output logic                       anim_done
);

    localparam int ADDR_W = $clog2(SPR_W * SPR_H * FRAMES);
    localparam int FN_W   = $clog2(FRAMES);
    localparam int SX_W   = $clog2(SPR_W);
    localparam int SY_W   = $clog2(SPR_H);
    localparam int CW     = COORD_W + 1;
    localparam logic [CW-1:0] SPAN_X = CW'(SPR_W << SCALE_SHIFT);
    localparam logic [CW-1:0] SPAN_Y = CW'(SPR_H << SCALE_SHIFT);

    logic [COORD_W-1:0] pos_x_q, pos_y_q;
    logic               flip_q;
    logic [CW-1:0]      dx, dy;
    logic               in_x, in_y, hit;
    logic [SX_W-1:0]    sx_raw, sx;
    logic [SY_W-1:0]    sy;
    logic [ADDR_W-1:0]  addr, rom_addr_q;
    logic               hit_d, blank_d;
    logic               on_n;

    sprite_anim_ctrl #(
        .FRAMES      (FRAMES),
        .FRAME_TICKS (FRAME_TICKS),
        .FN_W        (FN_W)
    ) u_ctrl (
        .clk          (vga_clk),
        .rst_n        (reset_n),
        .frame_start  (frame_start),
        .loop_mode    (loop_mode),
        .anim_en      (anim_en),
        .anim_restart (anim_restart),
        .frame_num    (frame_num),
        .anim_done    (anim_done)
    );

    // 11-bit offsets so a sprite near the right/bottom edge never wraps
    assign dx   = {1'b0, DrawX} - {1'b0, pos_x_q};
    assign dy   = {1'b0, DrawY} - {1'b0, pos_y_q};
    assign in_x = (DrawX >= pos_x_q) && (dx < SPAN_X);
    assign in_y = (DrawY >= pos_y_q) && (dy < SPAN_Y);
    assign hit  = in_x && in_y;

    assign sx_raw = dx[SCALE_SHIFT +: SX_W];
    assign sy     = dy[SCALE_SHIFT +: SY_W];
    assign sx     = flip_q ? ~sx_raw : sx_raw;

    assign addr = ADDR_W'(frame_num) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(sy) * ADDR_W'(SPR_W)
                + ADDR_W'(sx);

    assign on_n = hit_d && blank_d && (rom.rom_q != IDX_W'(TRANSP_IDX));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            flip_q     <= 1'b0;
            rom_addr_q <= '0;
            hit_d      <= 1'b0;
            blank_d    <= 1'b0;
            pixel_on   <= 1'b0;
            pixel_idx  <= '0;
        end else begin
            if (frame_start) begin
                pos_x_q <= pos_x;
                pos_y_q <= pos_y;
                flip_q  <= flip_h;
            end
            if (hit) rom_addr_q <= addr;
            hit_d     <= hit;
            blank_d   <= blank;
            pixel_on  <= on_n;
            pixel_idx <= on_n ? rom.rom_q : '0;
        end
    end

    assign rom.rom_addr = rom_addr_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator with a combinational ROM model.
// ROM holds (addr % 15) + 1 except addr 130, which is transparent.
module tb_sprite_animator;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY, pos_x, pos_y;
    logic       blank, frame_start, flip_h;
    logic       loop_mode, anim_en, anim_restart;
    logic       pixel_on;
    logic [3:0] pixel_idx;
    logic [1:0] frame_num;
    logic       anim_done;
    logic [3:0] rom [0:16383];

    int tests = 0;
    int fails = 0;

    sprite_animator_if #(.ADDR_W(14), .IDX_W(4)) rom_bus ();

    assign rom_bus.rom_q = rom[rom_bus.rom_addr];

    sprite_animator dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank        (blank),
        .frame_start  (frame_start),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .flip_h       (flip_h),
        .loop_mode    (loop_mode),
        .anim_en      (anim_en),
        .anim_restart (anim_restart),
        .rom          (rom_bus.master),
        .pixel_on     (pixel_on),
        .pixel_idx    (pixel_idx),
        .frame_num    (frame_num),
        .anim_done    (anim_done)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic drive_pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge vga_clk);
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic test_reset();
        pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0;
        pulse_fs();
        blank = 1'b1;
        drive_pix(110, 60);
        tests++;
        if (pixel_on !== 1'b1 || pixel_idx !== 4'd11) begin
            $display("FAIL pre_reset: on=%0b idx=%0d want 1/11", pixel_on, pixel_idx);
            fails++;
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (pixel_on !== 1'b0 || pixel_idx !== 4'd0) begin
            $display("FAIL reset_pix: on=%0b idx=%0d want 0/0", pixel_on, pixel_idx);
            fails++;
        end
        tests++;
        if (rom_bus.rom_addr !== 14'd0) begin
            $display("FAIL reset_addr: got %0d want 0", rom_bus.rom_addr);
            fails++;
        end
        tests++;
        if (frame_num !== 2'd0 || anim_done !== 1'b0) begin
            $display("FAIL reset_anim: frame=%0d done=%0b want 0/0", frame_num, anim_done);
            fails++;
        end
        @(negedge vga_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        tests++;
        if (frame_num !== 2'd0) begin
            $display("FAIL post_reset_frame: got %0d want 0", frame_num);
            fails++;
        end
    endtask

    task automatic test_place();
        pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0;
        pulse_fs();
        drive_pix(99, 50);
        tests++;
        if (pixel_on !== 1'b0) begin
            $display("FAIL left_edge_out: on=%0b want 0", pixel_on);
            fails++;
        end
        DrawX = 10'd100;
        @(negedge vga_clk);
        tests++;
        if (pixel_on !== 1'b0 || rom_bus.rom_addr !== 14'd0) begin
            $display("FAIL latency1: on=%0b addr=%0d want 0/0", pixel_on, rom_bus.rom_addr);
            fails++;
        end
        @(negedge vga_clk);
        tests++;
        if (pixel_on !== 1'b1 || pixel_idx !== 4'd1) begin
            $display("FAIL latency2: on=%0b idx=%0d want 1/1", pixel_on, pixel_idx);
            fails++;
        end
        DrawX = 10'd101;
        @(negedge vga_clk);
        tests++;
        if (rom_bus.rom_addr !== 14'd0) begin
            $display("FAIL addr_x101: got %0d want 0", rom_bus.rom_addr);
            fails++;
        end
        DrawX = 10'd102;
        @(negedge vga_clk);
        tests++;
        if (rom_bus.rom_addr !== 14'd1) begin
            $display("FAIL addr_x102: got %0d want 1", rom_bus.rom_addr);
            fails++;
        end
        drive_pix(102, 52);
        tests++;
        if (rom_bus.rom_addr !== 14'd65 || pixel_idx !== 4'd6) begin
            $display("FAIL addr_row1: addr=%0d idx=%0d want 65/6", rom_bus.rom_addr, pixel_idx);
            fails++;
        end
        drive_pix(227, 177);
        tests++;
        if (pixel_on !== 1'b1 || rom_bus.rom_addr !== 14'd4095 || pixel_idx !== 4'd1) begin
            $display("FAIL corner: on=%0b addr=%0d idx=%0d want 1/4095/1",
                     pixel_on, rom_bus.rom_addr, pixel_idx);
            fails++;
        end
        drive_pix(228, 177);
        tests++;
        if (pixel_on !== 1'b0 || pixel_idx !== 4'd0) begin
            $display("FAIL right_out: on=%0b idx=%0d want 0/0", pixel_on, pixel_idx);
            fails++;
        end
        drive_pix(150, 178);
        tests++;
        if (pixel_on !== 1'b0) begin
            $display("FAIL bottom_out: on=%0b want 0", pixel_on);
            fails++;
        end
    endtask

    task automatic test_flip_transp();
        flip_h = 1'b1;
        pulse_fs();
        drive_pix(100, 50);
        tests++;
        if (rom_bus.rom_addr !== 14'd63 || pixel_idx !== 4'd4) begin
            $display("FAIL flip: addr=%0d idx=%0d want 63/4", rom_bus.rom_addr, pixel_idx);
            fails++;
        end
        flip_h = 1'b0;
        pulse_fs();
        drive_pix(104, 54);
        tests++;
        if (rom_bus.rom_addr !== 14'd130 || pixel_on !== 1'b0 || pixel_idx !== 4'd0) begin
            $display("FAIL transp: addr=%0d on=%0b idx=%0d want 130/0/0",
                     rom_bus.rom_addr, pixel_on, pixel_idx);
            fails++;
        end
        blank = 1'b0;
        drive_pix(110, 60);
        tests++;
        if (pixel_on !== 1'b0 || pixel_idx !== 4'd0) begin
            $display("FAIL blank: on=%0b idx=%0d want 0/0", pixel_on, pixel_idx);
            fails++;
        end
        blank = 1'b1;
    endtask

    task automatic test_clip();
        pos_x = 10'd600; pos_y = 10'd50;
        pulse_fs();
        drive_pix(599, 60);
        tests++;
        if (pixel_on !== 1'b0) begin
            $display("FAIL clip_x599: on=%0b want 0", pixel_on);
            fails++;
        end
        drive_pix(600, 60);
        tests++;
        if (pixel_on !== 1'b1 || pixel_idx !== 4'd6) begin
            $display("FAIL clip_x600: on=%0b idx=%0d want 1/6", pixel_on, pixel_idx);
            fails++;
        end
        drive_pix(639, 60);
        tests++;
        if (pixel_on !== 1'b1 || pixel_idx !== 4'd10) begin
            $display("FAIL clip_x639: on=%0b idx=%0d want 1/10", pixel_on, pixel_idx);
            fails++;
        end
        drive_pix(0, 60);
        tests++;
        if (pixel_on !== 1'b0) begin
            $display("FAIL clip_x0: on=%0b want 0", pixel_on);
            fails++;
        end
        pos_y = 10'd450;
        pulse_fs();
        drive_pix(610, 479);
        tests++;
        if (pixel_on !== 1'b1 || pixel_idx !== 4'd2) begin
            $display("FAIL clip_y479: on=%0b idx=%0d want 1/2", pixel_on, pixel_idx);
            fails++;
        end
        drive_pix(610, 0);
        tests++;
        if (pixel_on !== 1'b0) begin
            $display("FAIL clip_y0: on=%0b want 0", pixel_on);
            fails++;
        end
        pos_x = 10'd1000; pos_y = 10'd0;
        pulse_fs();
        drive_pix(50, 10);
        tests++;
        if (pixel_on !== 1'b0) begin
            $display("FAIL no_wrap: on=%0b want 0", pixel_on);
            fails++;
        end
    endtask

    task automatic test_loop();
        pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0;
        loop_mode = 1'b1;
        anim_en = 1'b1;
        anim_restart = 1'b1;
        @(negedge vga_clk);
        anim_restart = 1'b0;
        @(negedge vga_clk);
        for (int p = 1; p <= 24; p++) begin
            pulse_fs();
            if (p == 5) begin
                tests++;
                if (frame_num !== 2'd0) begin
                    $display("FAIL loop_p5: got %0d want 0", frame_num);
                    fails++;
                end
            end
            if (p % 6 == 0) begin
                tests++;
                if (frame_num !== 2'((p / 6) % 4)) begin
                    $display("FAIL loop_p%0d: got %0d want %0d", p, frame_num, (p / 6) % 4);
                    fails++;
                end
            end
            if (p == 6) begin
                drive_pix(100, 50);
                tests++;
                if (rom_bus.rom_addr !== 14'd4096 || pixel_idx !== 4'd2) begin
                    $display("FAIL frame1_addr: addr=%0d idx=%0d want 4096/2",
                             rom_bus.rom_addr, pixel_idx);
                    fails++;
                end
            end
        end
        repeat (3) pulse_fs();
        anim_en = 1'b0;
        @(negedge vga_clk);
        repeat (10) pulse_fs();
        tests++;
        if (frame_num !== 2'd0) begin
            $display("FAIL pause_frame: got %0d want 0", frame_num);
            fails++;
        end
        anim_en = 1'b1;
        @(negedge vga_clk);
        repeat (2) pulse_fs();
        tests++;
        if (frame_num !== 2'd0) begin
            $display("FAIL pause_tick_hold: got %0d want 0", frame_num);
            fails++;
        end
        pulse_fs();
        tests++;
        if (frame_num !== 2'd1) begin
            $display("FAIL pause_resume: got %0d want 1", frame_num);
            fails++;
        end
    endtask

    task automatic test_oneshot();
        loop_mode = 1'b0;
        anim_restart = 1'b1;
        @(negedge vga_clk);
        anim_restart = 1'b0;
        @(negedge vga_clk);
        tests++;
        if (frame_num !== 2'd0 || anim_done !== 1'b0) begin
            $display("FAIL restart: frame=%0d done=%0b want 0/0", frame_num, anim_done);
            fails++;
        end
        repeat (23) pulse_fs();
        tests++;
        if (frame_num !== 2'd3 || anim_done !== 1'b0) begin
            $display("FAIL oneshot_p23: frame=%0d done=%0b want 3/0", frame_num, anim_done);
            fails++;
        end
        pulse_fs();
        tests++;
        if (frame_num !== 2'd3 || anim_done !== 1'b1) begin
            $display("FAIL oneshot_p24: frame=%0d done=%0b want 3/1", frame_num, anim_done);
            fails++;
        end
        loop_mode = 1'b1;
        anim_en = 1'b0;
        repeat (3) pulse_fs();
        anim_en = 1'b1;
        repeat (6) pulse_fs();
        tests++;
        if (frame_num !== 2'd3 || anim_done !== 1'b1) begin
            $display("FAIL done_hold: frame=%0d done=%0b want 3/1", frame_num, anim_done);
            fails++;
        end
        anim_restart = 1'b1;
        frame_start = 1'b1;
        @(negedge vga_clk);
        anim_restart = 1'b0;
        frame_start = 1'b0;
        @(negedge vga_clk);
        tests++;
        if (frame_num !== 2'd0 || anim_done !== 1'b0) begin
            $display("FAIL restart_fs: frame=%0d done=%0b want 0/0", frame_num, anim_done);
            fails++;
        end
        repeat (5) pulse_fs();
        tests++;
        if (frame_num !== 2'd0) begin
            $display("FAIL restart_tick5: got %0d want 0", frame_num);
            fails++;
        end
        pulse_fs();
        tests++;
        if (frame_num !== 2'd1) begin
            $display("FAIL restart_tick6: got %0d want 1", frame_num);
            fails++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 4'((i % 15) + 1);
        rom[130] = 4'd0;
        reset_n = 1'b0;
        DrawX = '0; DrawY = '0; blank = 1'b0;
        frame_start = 1'b0; pos_x = '0; pos_y = '0; flip_h = 1'b0;
        loop_mode = 1'b1; anim_en = 1'b0; anim_restart = 1'b0;
        repeat (3) @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        test_reset();
        test_place();
        test_flip_transp();
        test_clip();
        test_loop();
        test_oneshot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
